mem_access_stage: RTL

- MEM pipeline stage between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns load/store fields into a data-memory request over a valid/ready handshake with variable-latency response.
- Aligns and sign/zero-extends load data into ram_data, which feeds the MEM/WB register's in_ram_data.
- Stalls the pipeline while an access is outstanding and flags misaligned or illegal accesses.

---
 rtl/mem_access_pkg.sv | 38 +++
 rtl/mem_access_stage_align.sv | 61 ++++++
 rtl/mem_access_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM stage.
// funct3 encodings, FSM states, access legality.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  function automatic logic is_legal_access(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:  ok = 1'b1;
      F3_H:  ok = ~a[0];
      F3_W:  ok = (a == 2'b00);
      F3_BU: ok = rd;
      F3_HU: ok = rd & ~a[0];
      default: ok = 1'b0;
    endcase
    if (rd == wr) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Byte-lane steering for stores and lane extraction
// with sign/zero extension for loads.
module load_store_align (
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_alo,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_alo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);
  import mem_access_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store strobes and replicated write data
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'h0;
    unique case (1'b1)
      (i_st_funct3 == F3_B): begin
        o_wstrb = 4'b0001 << i_st_alo;
        o_wdata = {4{i_st_data[7:0]}};
      end
      (i_st_funct3 == F3_H): begin
        o_wstrb = 4'b0011 << i_st_alo;
        o_wdata = {2{i_st_data[15:0]}};
      end
      (i_st_funct3 == F3_W): begin
        o_wstrb = 4'b1111;
        o_wdata = i_st_data;
      end
      default: ;
    endcase
  end

  // Select the addressed lane and extend it
  always_comb begin
    w_byte = 8'h0;
    w_half = i_ld_alo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_alo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    o_ld_data = 32'h0;
    unique case (1'b1)
      (i_ld_funct3 == F3_B):  o_ld_data = {{24{w_byte[7]}}, w_byte};
      (i_ld_funct3 == F3_BU): o_ld_data = {24'h0, w_byte};
      (i_ld_funct3 == F3_H):  o_ld_data = {{16{w_half[15]}}, w_half};
      (i_ld_funct3 == F3_HU): o_ld_data = {16'h0, w_half};
      (i_ld_funct3 == F3_W):  o_ld_data = i_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory handshake, stall,
// load alignment and fault reporting.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_address,
  input  logic [31:0] in_store_data,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ram_data,
  output logic        stall,
  output logic        out_valid,
  output logic        access_fault
);
  import mem_access_pkg::*;

  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_alo;
  logic [31:0] r_ram;

  logic        w_memop;
  logic        w_legal;
  logic        w_start;
  logic        w_bad;
  logic        w_tmo;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ld;

  load_store_align u_align (
    .i_st_funct3 (in_funct3),
    .i_st_alo    (in_address[1:0]),
    .i_st_data   (in_store_data),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_alo    (r_alo),
    .i_rdata     (dmem_rdata),
    .o_ld_data   (w_ld)
  );

  assign w_memop = in_valid & (in_mem_read | in_mem_write);
  assign w_legal = is_legal_access(in_mem_read, in_mem_write,
                                   in_funct3, in_address[1:0]);
  assign w_start = (r_state == IDLE) & w_memop & w_legal;
  assign w_bad   = (r_state == IDLE) & w_memop & ~w_legal;
  assign w_tmo   = TMO_EN & (r_state == WAIT) &
                   ~dmem_resp_valid & (r_cnt == TMO_LAST);

  assign stall = w_start | (r_state == REQ) | (r_state == WAIT);
  assign out_valid = ((r_state == IDLE) & in_valid & ~w_start) |
                     (r_state == DONE);
  assign access_fault   = w_bad | w_tmo;
  assign dmem_req_valid = (r_state == REQ);
  assign dmem_addr      = r_addr;
  assign dmem_we        = r_we;
  assign dmem_wstrb     = r_wstrb;
  assign dmem_wdata     = r_wdata;
  assign ram_data       = r_ram;

  // Access FSM, request latches, timeout counter, load result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= 32'h0;
      r_addr   <= 32'h0;
      r_we     <= 1'b0;
      r_wstrb  <= 4'h0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'h0;
      r_alo    <= 2'h0;
      r_ram    <= 32'h0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= 32'h0;
          if (w_start) begin
            r_addr   <= {in_address[31:2], 2'b00};
            r_we     <= in_mem_write;
            r_wstrb  <= in_mem_write ? w_wstrb : 4'h0;
            r_wdata  <= in_mem_write ? w_wdata : 32'h0;
            r_funct3 <= in_funct3;
            r_alo    <= in_address[1:0];
            r_state  <= REQ;
          end else if (w_bad) begin
            r_ram <= 32'h0;
          end
        end
        REQ: begin
          if (dmem_req_ready)
            r_state <= r_we ? DONE : WAIT;
        end
        WAIT: begin
          if (dmem_resp_valid) begin
            r_ram   <= w_ld;
            r_cnt   <= 32'h0;
            r_state <= DONE;
          end else if (w_tmo) begin
            r_ram   <= 32'h0;
            r_cnt   <= 32'h0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
